// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage: widths, ALU op codes,
// forwarding selects, the EX control bundle and the stage action encoding.
package id_ex_stage_pkg;

  localparam int REG_AW   = 6;
  localparam int DW       = 32;
  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] aluOp_t;

  localparam aluOp_t ALU_ADD = 4'h0;
  localparam aluOp_t ALU_SUB = 4'h1;
  localparam aluOp_t ALU_AND = 4'h2;
  localparam aluOp_t ALU_OR  = 4'h3;
  localparam aluOp_t ALU_XOR = 4'h4;
  localparam aluOp_t ALU_SLT = 4'h5;
  localparam aluOp_t ALU_SLL = 4'h6;
  localparam aluOp_t ALU_SRL = 4'h7;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // A bubble is simply '0 of this struct: invalid, no side effects.
  typedef struct packed {
    logic   valid;
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    logic   memToReg;
    logic   aluSrc;
    logic   branch;
    aluOp_t aluOp;
  } ex_ctrl_t;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2
  } stageAct_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and registered EX-side outputs of the ID/EX stage.
// master = the decode/testbench side, slave = the pipeline register.
interface id_ex_stage_if #(
  parameter int REG_AW = 6,
  parameter int DW     = 32
);

  logic                                   id_valid;
  logic [DW-1:0]                          id_pc, id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0]                      id_rs, id_rt, id_rd;
  logic                                   id_reg_write, id_mem_read, id_mem_write;
  logic                                   id_mem_to_reg, id_alu_src, id_reg_dst, id_branch;
  logic [id_ex_stage_pkg::ALU_OP_W-1:0]   id_alu_op;

  logic                                   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic                                   ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [id_ex_stage_pkg::ALU_OP_W-1:0]   ex_alu_op;
  logic [DW-1:0]                          ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0]                      ex_rs, ex_rt, ex_wreg;

  modport master (
    output id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
           id_reg_dst, id_branch, id_alu_op,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_branch, ex_alu_op, ex_pc, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_wreg
  );

  modport slave (
    input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
           id_reg_dst, id_branch, id_alu_op,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_branch, ex_alu_op, ex_pc, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_wreg
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare plus the hold/flush/stall priority that decides what the
// ID/EX register does this cycle and whether the front end may advance.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = 6
) (
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exWreg,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              exFlush,
  input  logic              hold,
  output stageAct_e         action,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              stallEvent,
  output logic              flushEvent
);

  logic loadUse;

  assign loadUse = exValid & exMemRead & (exWreg != '0) & idValid &
                   ((exWreg == idRs) | (exWreg == idRt));

  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    action     = ACT_CAPTURE;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    stallEvent = 1'b0;
    flushEvent = 1'b0;
    if (hold) begin
      action    = ACT_HOLD;
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
    end else if (exFlush) begin
      // IF/ID flushing is handled upstream, so the front end keeps moving.
      action     = ACT_BUBBLE;
      flushEvent = 1'b1;
    end else if (loadUse) begin
      action     = ACT_BUBBLE;
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      stallEvent = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, inserts bubbles on
// flush or load-use, freezes on hold, and counts stall/flush events.
module id_ex_stage #(
  parameter int REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int DW     = id_ex_stage_pkg::DW,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus,
  input  logic          ex_flush,
  input  logic          hold,
  output logic          pc_write,
  output logic          if_id_write,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);

  import id_ex_stage_pkg::ex_ctrl_t;
  import id_ex_stage_pkg::stageAct_e;
  import id_ex_stage_pkg::ACT_CAPTURE;
  import id_ex_stage_pkg::ACT_BUBBLE;

  ex_ctrl_t          ctrlQ;
  logic [DW-1:0]     pcQ, rsDataQ, rtDataQ, immQ;
  logic [REG_AW-1:0] rsQ, rtQ, wregQ;
  stageAct_e         action;
  logic              stallEvent, flushEvent;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .exValid    (ctrlQ.valid),
    .exMemRead  (ctrlQ.memRead),
    .exWreg     (wregQ),
    .idValid    (bus.id_valid),
    .idRs       (bus.id_rs),
    .idRt       (bus.id_rt),
    .exFlush    (ex_flush),
    .hold       (hold),
    .action     (action),
    .pcWrite    (pc_write),
    .ifIdWrite  (if_id_write),
    .stallEvent (stallEvent),
    .flushEvent (flushEvent)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst || action == ACT_BUBBLE) begin
      // Zeroed indices make the forwarding unit see register 0 and stay idle.
      ctrlQ   <= '0;
      pcQ     <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      immQ    <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      wregQ   <= '0;
    end else if (action == ACT_CAPTURE) begin
      ctrlQ   <= '{valid:    bus.id_valid,
                   regWrite: bus.id_reg_write,
                   memRead:  bus.id_mem_read,
                   memWrite: bus.id_mem_write,
                   memToReg: bus.id_mem_to_reg,
                   aluSrc:   bus.id_alu_src,
                   branch:   bus.id_branch,
                   aluOp:    bus.id_alu_op};
      pcQ     <= bus.id_pc;
      rsDataQ <= bus.id_rs_data;
      rtDataQ <= bus.id_rt_data;
      immQ    <= bus.id_imm;
      rsQ     <= bus.id_rs;
      rtQ     <= bus.id_rt;
      wregQ   <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallEvent && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flushEvent && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.ex_valid      = ctrlQ.valid;
  assign bus.ex_reg_write  = ctrlQ.regWrite;
  assign bus.ex_mem_read   = ctrlQ.memRead;
  assign bus.ex_mem_write  = ctrlQ.memWrite;
  assign bus.ex_mem_to_reg = ctrlQ.memToReg;
  assign bus.ex_alu_src    = ctrlQ.aluSrc;
  assign bus.ex_branch     = ctrlQ.branch;
  assign bus.ex_alu_op     = ctrlQ.aluOp;
  assign bus.ex_pc         = pcQ;
  assign bus.ex_rs_data    = rsDataQ;
  assign bus.ex_rt_data    = rtDataQ;
  assign bus.ex_imm        = immQ;
  assign bus.ex_rs         = rsQ;
  assign bus.ex_rt         = rtQ;
  assign bus.ex_wreg       = wregQ;

endmodule
